// File: rtl/sample_byte_serializer.sv
// Serializes each accepted 32-bit capture word into bytes for the host link,
// skipping disabled channel groups and holding the controller off while busy.
module sample_byte_serializer #(
    parameter int BYTE_GAP = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        send,
    input  logic [31:0] dataIn,
    input  logic [3:0]  disabledGroups,
    input  logic        clear,
    output logic        busy,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        overrun
);
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(BYTE_GAP - 1);

    state_t      state_reg, state_next;
    logic [31:0] word_reg, word_next;
    logic [3:0]  pend_reg, pend_next;
    logic [1:0]  idx_reg, idx_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic        busy_reg, busy_next;
    logic        valid_reg, valid_next;
    logic [7:0]  data_reg, data_next;
    logic        overrun_reg, overrun_next;

    logic [3:0]  en_groups;
    logic [3:0]  pend_left;
    logic [7:0]  word_bytes [4];
    logic [7:0]  in_bytes [4];

    function automatic logic [1:0] lowest(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[8*gi +: 8];
            assign in_bytes[gi]   = dataIn[8*gi +: 8];
        end
    endgenerate

    assign en_groups = ~disabledGroups;
    // Groups still owed after the byte currently offered is taken.
    assign pend_left = pend_reg & ~(4'b0001 << idx_reg);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            word_reg    <= '0;
            pend_reg    <= '0;
            idx_reg     <= '0;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            pend_reg    <= pend_next;
            idx_reg     <= idx_next;
            gap_cnt_reg <= gap_cnt_next;
            busy_reg    <= busy_next;
            valid_reg   <= valid_next;
            data_reg    <= data_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        pend_next    = pend_reg;
        idx_next     = idx_reg;
        gap_cnt_next = gap_cnt_reg;
        busy_next    = busy_reg;
        valid_next   = valid_reg;
        data_next    = data_reg;

        // A dropped send outranks a simultaneous clear.
        if (send && busy_reg) begin
            overrun_next = 1'b1;
        end else if (clear) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg;
        end

        case (state_reg)
            IDLE: begin
                busy_next  = 1'b0;
                valid_next = 1'b0;
                if (send && !busy_reg) begin
                    word_next = dataIn;
                    pend_next = en_groups;
                    busy_next = 1'b1;
                    if (en_groups != 4'd0) begin
                        state_next = ACTIVE;
                        idx_next   = lowest(en_groups);
                        valid_next = 1'b1;
                        data_next  = in_bytes[lowest(en_groups)];
                    end
                end
            end
            ACTIVE: begin
                if (byte_ready) begin
                    pend_next = pend_left;
                    if (pend_left == 4'd0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        valid_next = 1'b0;
                    end else if (BYTE_GAP > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                        valid_next   = 1'b0;
                    end else begin
                        idx_next  = lowest(pend_left);
                        data_next = word_bytes[lowest(pend_left)];
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == 8'd0) begin
                    state_next = ACTIVE;
                    idx_next   = lowest(pend_reg);
                    valid_next = 1'b1;
                    data_next  = word_bytes[lowest(pend_reg)];
                end else begin
                    gap_cnt_next = gap_cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = busy_reg;
    assign byte_valid = valid_reg;
    assign byte_data  = data_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sample_byte_serializer.sv
// Bench for sample_byte_serializer: two instances (no gap, gap of 3) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sample_byte_serializer;
    localparam int GAP1 = 3;

    logic        clock = 1'b0;
    logic        resetn;
    logic        send;
    logic [31:0] dataIn;
    logic [3:0]  disabledGroups;
    logic        clear;
    logic        byteReady;

    logic [1:0]  dBusy;
    logic [1:0]  dValid;
    logic [1:0]  dOvr;
    logic [15:0] dData;

    int tests = 0;
    int fails = 0;

    // Model: per instance, a list of bytes still owed plus a gap countdown.
    logic [7:0] mq [2][4];
    int         mlen [2];
    int         mhead [2];
    int         mgap [2];
    bit         mpulse [2];
    bit         movr [2];

    // Observation logs for directed checks.
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];
    int busyCnt0, busyCnt1, validCnt0, validCnt1;

    sample_byte_serializer #(.BYTE_GAP(0)) dut0 (
        .clock(clock), .resetn(resetn), .send(send), .dataIn(dataIn),
        .disabledGroups(disabledGroups), .clear(clear), .busy(dBusy[0]),
        .byte_valid(dValid[0]), .byte_data(dData[7:0]), .byte_ready(byteReady),
        .overrun(dOvr[0])
    );

    sample_byte_serializer #(.BYTE_GAP(GAP1)) dut1 (
        .clock(clock), .resetn(resetn), .send(send), .dataIn(dataIn),
        .disabledGroups(disabledGroups), .clear(clear), .busy(dBusy[1]),
        .byte_valid(dValid[1]), .byte_data(dData[15:8]), .byte_ready(byteReady),
        .overrun(dOvr[1])
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int inst, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, inst, $time, got, exp);
        end
    endtask

    function automatic int gapOf(input int i);
        return (i == 0) ? 0 : GAP1;
    endfunction

    // Model update on each active edge, inputs are stable since they change #1 after it.
    initial begin
        forever begin
            @(posedge clock or negedge resetn);
            for (int i = 0; i < 2; i++) begin
                int  left;
                bit  bz;
                bit  v;
                if (!resetn) begin
                    mlen[i] = 0; mhead[i] = 0; mgap[i] = 0; mpulse[i] = 0; movr[i] = 0;
                end else begin
                    left = mlen[i] - mhead[i];
                    bz   = (left > 0) || mpulse[i];
                    v    = (left > 0) && (mgap[i] == 0);
                    if (send && bz) movr[i] = 1;
                    else if (clear) movr[i] = 0;
                    mpulse[i] = 0;
                    if (v && byteReady) begin
                        mhead[i]++;
                        if (mhead[i] < mlen[i]) mgap[i] = gapOf(i);
                    end else if (mgap[i] > 0) begin
                        mgap[i]--;
                    end
                    if (send && !bz) begin
                        mlen[i] = 0;
                        mhead[i] = 0;
                        for (int g = 0; g < 4; g++) begin
                            if (!disabledGroups[g]) begin
                                mq[i][mlen[i]] = dataIn[8*g +: 8];
                                mlen[i]++;
                            end
                        end
                        if (mlen[i] == 0) mpulse[i] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison and logging, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                bit eValid;
                bit eBusy;
                eValid = (mlen[i] > mhead[i]) && (mgap[i] == 0);
                eBusy  = (mlen[i] > mhead[i]) || mpulse[i];
                check("busy", i, 32'(dBusy[i]), 32'(eBusy));
                check("byte_valid", i, 32'(dValid[i]), 32'(eValid));
                check("overrun", i, 32'(dOvr[i]), 32'(movr[i]));
                if (eValid) check("byte_data", i, 32'(dData[8*i +: 8]), 32'(mq[i][mhead[i]]));
            end
            if (resetn) begin
                if (dBusy[0]) busyCnt0++;
                if (dBusy[1]) busyCnt1++;
                if (dValid[0]) validCnt0++;
                if (dValid[1]) validCnt1++;
                if (dValid[0] && byteReady) got0.push_back(dData[7:0]);
                if (dValid[1] && byteReady) got1.push_back(dData[15:8]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearLogs();
        got0.delete();
        got1.delete();
        busyCnt0 = 0; busyCnt1 = 0; validCnt0 = 0; validCnt1 = 0;
    endtask

    task automatic sendWord(input logic [31:0] w, input logic [3:0] d);
        send = 1'b1;
        dataIn = w;
        disabledGroups = d;
        tick();
        send = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (dBusy != 2'b00 && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", 0, 32'(dBusy), 32'd0);
    endtask

    task automatic checkStream(input string name, input int inst, input int n,
                               input logic [31:0] exp);
        int sz;
        sz = (inst == 0) ? got0.size() : got1.size();
        check({name, "_len"}, inst, 32'(sz), 32'(n));
        for (int k = 0; k < n && k < sz; k++) begin
            check(name, inst, 32'((inst == 0) ? got0[k] : got1[k]), 32'(exp[8*k +: 8]));
        end
    endtask

    initial begin
        resetn = 1'b0;
        send = 1'b0;
        dataIn = '0;
        disabledGroups = '0;
        clear = 1'b0;
        byteReady = 1'b1;
        tick();
        tick();
        check("rst_busy", 0, 32'(dBusy), 32'd0);
        check("rst_valid", 0, 32'(dValid), 32'd0);
        check("rst_data", 0, 32'(dData), 32'd0);
        check("rst_ovr", 0, 32'(dOvr), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic word, all groups enabled.
        clearLogs();
        sendWord(32'h44332211, 4'h0);
        check("first_byte_latency", 0, 32'(dValid), 32'b11);
        waitIdle();
        checkStream("basic", 0, 4, 32'h44332211);
        checkStream("basic", 1, 4, 32'h44332211);
        check("basic_busy_cycles", 0, 32'(busyCnt0), 32'd4);
        check("gap_busy_cycles", 1, 32'(busyCnt1), 32'd13);
        check("gap_valid_cycles", 1, 32'(validCnt1), 32'd4);
        check("basic_ovr", 0, 32'(dOvr), 32'd0);
        tick();

        // Group skip.
        clearLogs();
        sendWord(32'hDDCCBBAA, 4'b0101);
        waitIdle();
        checkStream("skip", 0, 2, 32'h0000DDBB);
        check("skip_busy_cycles", 0, 32'(busyCnt0), 32'd2);
        check("skip_busy_cycles", 1, 32'(busyCnt1), 32'd5);
        tick();

        // Backpressure on the second byte.
        clearLogs();
        sendWord(32'h44332211, 4'h0);
        tick();
        byteReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_data", 0, 32'(dData[7:0]), 32'h22);
            check("bp_hold_valid", 0, 32'(dValid[0]), 32'd1);
            tick();
        end
        byteReady = 1'b1;
        waitIdle();
        checkStream("bp", 0, 4, 32'h44332211);
        checkStream("bp", 1, 4, 32'h44332211);
        tick();

        // Send during byte 2 is dropped and flags overrun until cleared.
        clearLogs();
        sendWord(32'h87654321, 4'h0);
        tick();
        sendWord(32'hDEADBEEF, 4'h0);
        check("ovr_set", 0, 32'(dOvr), 32'b11);
        waitIdle();
        checkStream("ovr_stream", 0, 4, 32'h87654321);
        checkStream("ovr_stream", 1, 4, 32'h87654321);
        check("ovr_sticky", 0, 32'(dOvr), 32'b11);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_clear", 0, 32'(dOvr), 32'd0);

        // All groups disabled: one-cycle busy pulse, a send during it overruns.
        clearLogs();
        send = 1'b1;
        dataIn = 32'hCAFEF00D;
        disabledGroups = 4'hF;
        tick();
        check("pulse_busy", 0, 32'(dBusy), 32'b11);
        check("pulse_valid", 0, 32'(dValid), 32'd0);
        tick();
        send = 1'b0;
        check("pulse_end", 0, 32'(dBusy), 32'd0);
        check("pulse_ovr", 0, 32'(dOvr), 32'b11);
        tick();
        check("pulse_busy_cycles", 0, 32'(busyCnt0), 32'd1);
        check("pulse_valid_cycles", 0, 32'(validCnt0 + validCnt1), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Reset during byte 3 abandons the word.
        clearLogs();
        sendWord(32'h44332211, 4'h0);
        tick();
        tick();
        check("mid_byte3", 0, 32'(dData[7:0]), 32'h33);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", 0, 32'(dBusy), 32'd0);
        check("arst_valid", 0, 32'(dValid), 32'd0);
        check("arst_data", 0, 32'(dData), 32'd0);
        check("arst_ovr", 0, 32'(dOvr), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("no_resume", 0, 32'(dBusy | dValid), 32'd0);
        clearLogs();
        sendWord(32'h44332211, 4'h0);
        waitIdle();
        checkStream("after_rst", 0, 4, 32'h44332211);
        checkStream("after_rst", 1, 4, 32'h44332211);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            send = ($urandom_range(0, 3) == 0);
            dataIn = $urandom;
            disabledGroups = 4'($urandom);
            byteReady = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 15) == 0);
            tick();
        end
        send = 1'b0;
        clear = 1'b0;
        byteReady = 1'b1;
        waitIdle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
